// File: rtl/fifo_err_inj_sched.sv
// Periodic ECC self-test scheduler: round-robins single/double-bit injection pulses into
// M FIFO lanes, waits for the matching error flag and logs per-lane pass/fail.
module fifo_err_inj_sched #(
  parameter int unsigned M       = 3,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic [15:0]      period_i,
  input  logic [1:0]       mode_i,
  output logic [M-1:0]     injectsbiterr_o,
  output logic [M-1:0]     injectdbiterr_o,
  input  logic [M-1:0]     lane_sbiterr_i,
  input  logic [M-1:0]     lane_dbiterr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [M-1:0]     lane_fail_o,
  output logic [CNT_W-1:0] fail_cnt_o
);

  localparam int unsigned LW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StWait, StInject, StCheck, StNext} state_e;

  state_e           state_q;
  logic [15:0]      wait_cnt_q;
  logic [TW-1:0]    timer_q;
  logic [LW-1:0]    lane_q;
  logic             type_dbit_q;
  logic             cur_dbit_q;
  logic             cur_alt_q;
  logic [M-1:0]     inj_s_q;
  logic [M-1:0]     inj_d_q;
  logic             done_q;
  logic             pass_q;
  logic [M-1:0]     lane_fail_q;
  logic [CNT_W-1:0] fail_cnt_q;

  logic [M-1:0] lane_oh;
  logic [15:0]  period_eff;
  logic         inj_dbit_sel;
  logic         lane_last;
  logic         exp_hit;
  logic         wrong_hit;
  logic         other_hit;
  logic         pass_now;
  logic         fail_now;

  always_comb begin
    lane_oh = '0;
    for (int unsigned i = 0; i < M; i++) begin
      lane_oh[i] = (lane_q == LW'(i));
    end
  end

  always_comb begin
    period_eff   = (period_i == 16'd0) ? 16'd1 : period_i;
    inj_dbit_sel = (mode_i == 2'd1) || ((mode_i == 2'd2) && type_dbit_q);
    lane_last    = (lane_q == LW'(M - 1));
    exp_hit      = cur_dbit_q ? |(lane_dbiterr_i & lane_oh) : |(lane_sbiterr_i & lane_oh);
    wrong_hit    = cur_dbit_q ? |(lane_sbiterr_i & lane_oh) : |(lane_dbiterr_i & lane_oh);
    other_hit    = |((lane_sbiterr_i | lane_dbiterr_i) & ~lane_oh);
    pass_now     = exp_hit && !wrong_hit && !other_hit;
    // A clean expected flag on the last timer cycle still counts as a pass.
    fail_now     = wrong_hit || other_hit || (!exp_hit && (timer_q == TW'(1)));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      timer_q     <= '0;
      lane_q      <= '0;
      type_dbit_q <= 1'b0;
      cur_dbit_q  <= 1'b0;
      cur_alt_q   <= 1'b0;
      inj_s_q     <= '0;
      inj_d_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      lane_fail_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      inj_s_q <= '0;
      inj_d_q <= '0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable_i) begin
            state_q    <= StWait;
            wait_cnt_q <= period_eff;
          end
        end
        StWait: begin
          if (!enable_i) begin
            state_q <= StIdle;
          end else if (wait_cnt_q <= 16'd1) begin
            state_q    <= StInject;
            cur_dbit_q <= inj_dbit_sel;
            cur_alt_q  <= (mode_i == 2'd2);
            if (inj_dbit_sel) inj_d_q <= lane_oh;
            else              inj_s_q <= lane_oh;
          end else begin
            wait_cnt_q <= wait_cnt_q - 16'd1;
          end
        end
        StInject: begin
          // The pulse register self-clears, so an abort here still yields one full pulse.
          if (!enable_i) begin
            state_q <= StIdle;
          end else begin
            state_q <= StCheck;
            timer_q <= TW'(TIMEOUT);
          end
        end
        StCheck: begin
          if (!enable_i) begin
            state_q <= StIdle;
          end else if (pass_now || fail_now) begin
            state_q <= StNext;
            done_q  <= 1'b1;
            pass_q  <= pass_now;
            if (!pass_now) begin
              lane_fail_q <= lane_fail_q | lane_oh;
              if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        StNext: begin
          lane_q <= lane_last ? '0 : lane_q + LW'(1);
          if (cur_alt_q && lane_last) type_dbit_q <= ~type_dbit_q;
          if (enable_i) begin
            state_q    <= StWait;
            wait_cnt_q <= period_eff;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign injectsbiterr_o = inj_s_q;
  assign injectdbiterr_o = inj_d_q;
  assign busy_o          = (state_q != StIdle);
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign lane_fail_o     = lane_fail_q;
  assign fail_cnt_o      = fail_cnt_q;

endmodule

// File: tb/tb_fifo_err_inj_sched.sv
// Directed bench for fifo_err_inj_sched with a 3-cycle echoing lane model per lane.
module tb_fifo_err_inj_sched;

  localparam int M  = 3;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          enable_i;
  logic [15:0]   period_i;
  logic [1:0]    mode_i;
  logic [M-1:0]  injs, injd, lsb, ldb;
  logic          busy, done, pass;
  logic [M-1:0]  lane_fail;
  logic [CW-1:0] fail_cnt;

  // lane model: 0 = echo matching flag, 1 = silent, 2 = echo wrong flag
  logic [1:0]   resp [M];
  logic [M-1:0] spur_s = '0;
  logic [M-1:0] s1 = '0, s2 = '0, s3 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [M-1:0] ms, md;

  int checks = 0;
  int errors = 0;
  int onehot_err = 0;

  fifo_err_inj_sched #(.M(M), .TIMEOUT(32), .CNT_W(CW)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .enable_i       (enable_i),
    .period_i       (period_i),
    .mode_i         (mode_i),
    .injectsbiterr_o(injs),
    .injectdbiterr_o(injd),
    .lane_sbiterr_i (lsb),
    .lane_dbiterr_i (ldb),
    .busy_o         (busy),
    .done_o         (done),
    .pass_o         (pass),
    .lane_fail_o    (lane_fail),
    .fail_cnt_o     (fail_cnt)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    s1 <= injs; s2 <= s1; s3 <= s2;
    d1 <= injd; d2 <= d1; d3 <= d2;
  end

  always_comb begin
    ms = '0;
    md = '0;
    for (int l = 0; l < M; l++) begin
      case (resp[l])
        2'd0: begin ms[l] = s3[l]; md[l] = d3[l]; end
        2'd2: begin ms[l] = d3[l]; md[l] = s3[l]; end
        default: ;
      endcase
    end
  end
  assign lsb = ms | spur_s;
  assign ldb = md;

  always @(negedge clk_i) begin
    if ($countones({injs, injd}) > 1) onehot_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_inj(output int lane, output bit dbit, output int cyc);
    lane = -1; dbit = 1'b0; cyc = 0;
    for (int i = 1; i <= 300 && cyc == 0; i++) begin
      @(negedge clk_i);
      if (|(injs | injd)) begin
        cyc  = i;
        dbit = |injd;
        for (int l = 0; l < M; l++) if (injs[l] | injd[l]) lane = l;
      end
    end
  endtask

  task automatic wait_done(output bit p, output int cyc);
    p = 1'b0; cyc = 0;
    for (int i = 1; i <= 100 && cyc == 0; i++) begin
      @(negedge clk_i);
      if (done) begin
        cyc = i;
        p   = pass;
      end
    end
  endtask

  task automatic round(input string tag, input int elane, input bit edbit, input bit epass,
                       input int edone);
    int lane, cyc, dcyc;
    bit dbit, p;
    wait_inj(lane, dbit, cyc);
    wait_done(p, dcyc);
    chk({tag, ".lane"}, lane, elane);
    chk({tag, ".type"}, 32'(dbit), 32'(edbit));
    chk({tag, ".pass"}, 32'(p), 32'(epass));
    chk({tag, ".done_lat"}, dcyc, edone);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i  = 1'b0;
    enable_i = 1'b0;
    spur_s   = '0;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin
    int lane, cyc;
    bit dbit, p, seen;
    int alt_lane [7] = '{0, 1, 2, 0, 1, 2, 0};
    bit alt_type [7] = '{0, 0, 0, 1, 1, 1, 0};

    rst_n_i = 1'b0; enable_i = 1'b0; period_i = 16'd10; mode_i = 2'd0;
    for (int l = 0; l < M; l++) resp[l] = 2'd0;
    repeat (3) @(negedge clk_i);
    chk("rst.outs", {busy, done, pass, lane_fail, fail_cnt, injs, injd}, 32'd0);
    rst_n_i = 1'b1;

    // mode 0, period 10: lanes 0,1,2,0 all pass
    @(negedge clk_i);
    enable_i = 1'b1;
    wait_inj(lane, dbit, cyc);
    chk("lat.p10", cyc, 11);
    chk("lat.busy", 32'(busy), 1);
    chk("m0.r0.lane", lane, 0);
    chk("m0.r0.type", 32'(dbit), 0);
    wait_done(p, cyc);
    chk("m0.r0.done_lat", cyc, 4);
    chk("m0.r0.pass", 32'(p), 1);
    round("m0.r1", 1, 1'b0, 1'b1, 4);
    round("m0.r2", 2, 1'b0, 1'b1, 4);
    round("m0.r3", 0, 1'b0, 1'b1, 4);
    chk("m0.fail_cnt", fail_cnt, 0);
    chk("m0.lane_fail", lane_fail, 0);

    // mode 2 alternates type per full sweep
    do_reset();
    mode_i = 2'd2;
    enable_i = 1'b1;
    for (int r = 0; r < 7; r++) round($sformatf("m2.r%0d", r), alt_lane[r], alt_type[r], 1'b1, 4);
    chk("m2.fail_cnt", fail_cnt, 0);

    // lane 1 silent -> timeout after 32 check cycles, schedule continues on lane 2
    do_reset();
    mode_i = 2'd0;
    resp[1] = 2'd1;
    enable_i = 1'b1;
    round("to.r0", 0, 1'b0, 1'b1, 4);
    round("to.r1", 1, 1'b0, 1'b0, 33);
    chk("to.lane_fail", lane_fail, 3'b010);
    chk("to.fail_cnt", fail_cnt, 1);
    round("to.r2", 2, 1'b0, 1'b1, 4);
    resp[1] = 2'd0;

    // lane 0 answers with the wrong flag type
    do_reset();
    resp[0] = 2'd2;
    enable_i = 1'b1;
    round("wt.r0", 0, 1'b0, 1'b0, 4);
    chk("wt.lane_fail", lane_fail, 3'b001);
    chk("wt.fail_cnt", fail_cnt, 1);
    resp[0] = 2'd0;

    // spurious sbiterr on lane 2 during the lane 0 check
    do_reset();
    enable_i = 1'b1;
    wait_inj(lane, dbit, cyc);
    chk("sp.lane", lane, 0);
    @(negedge clk_i);
    spur_s = 3'b100;
    @(negedge clk_i);
    spur_s = '0;
    chk("sp.done", 32'(done), 1);
    chk("sp.pass", 32'(pass), 0);
    chk("sp.lane_fail", lane_fail, 3'b001);
    chk("sp.fail_cnt", fail_cnt, 1);

    // abort mid-check, then re-enable targets the same lane
    do_reset();
    enable_i = 1'b1;
    wait_inj(lane, dbit, cyc);
    @(negedge clk_i);
    enable_i = 1'b0;
    @(negedge clk_i);
    chk("ab.busy", 32'(busy), 0);
    seen = done;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      seen = seen | done;
    end
    chk("ab.no_done", 32'(seen), 0);
    chk("ab.fail_cnt", fail_cnt, 0);
    enable_i = 1'b1;
    round("ab.re", 0, 1'b0, 1'b1, 4);

    // period 0 acts as 1; all lanes silent drive the counter to saturation
    do_reset();
    period_i = 16'd0;
    for (int l = 0; l < M; l++) resp[l] = 2'd1;
    enable_i = 1'b1;
    wait_inj(lane, dbit, cyc);
    chk("lat.p0", cyc, 2);
    wait_done(p, cyc);
    chk("sat.first_done", cyc, 33);
    for (int r = 1; r < 15; r++) round($sformatf("sat.r%0d", r), r % 3, 1'b0, 1'b0, 33);
    chk("sat.cnt15", fail_cnt, 15);
    round("sat.r15", 0, 1'b0, 1'b0, 33);
    chk("sat.hold", fail_cnt, 15);
    chk("sat.lane_fail", lane_fail, 3'b111);

    // reset mid-check clears everything on the next clock
    wait_inj(lane, dbit, cyc);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    chk("rst.mid", {busy, done, pass, lane_fail, fail_cnt, injs, injd}, 32'd0);
    rst_n_i = 1'b1;

    chk("onehot", onehot_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
